// File: rtl/i2s_tx_gen_if.sv
// Sample handshake between the decoder sample path and the I2S transmitter.
// The producer drives a stereo pair with a valid flag; the transmitter answers
// with ready while its holding register is empty.
interface i2s_tx_gen_if #(
    parameter int SAMPLE_W = 16
);
    logic [SAMPLE_W-1:0] sample_left;
    logic [SAMPLE_W-1:0] sample_right;
    logic                sample_valid;
    logic                sample_ready;

    modport master (
        output sample_left, sample_right, sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_left, sample_right, sample_valid,
        output sample_ready
    );
endinterface

// File: rtl/i2s_tx_gen.sv
// Parametrised I2S / left-justified / right-justified transmitter.
// bclk toggles on every strobe; all serial outputs update on the clk where
// bclk falls. A one-deep holding register decouples the sample producer from
// frame timing; an empty register at frame start sends silence and flags
// underrun.
module i2s_tx_gen #(
    parameter int SAMPLE_W = 16,
    parameter int SLOT_W   = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         strobe,
    input  logic [1:0]   fmt,
    i2s_tx_gen_if.slave  smp,
    output logic         bclk,
    output logic         lrclk,
    output logic         sdata,
    output logic         underrun
);
    localparam int FRAME = 2 * SLOT_W;
    localparam int PW    = $clog2(FRAME);
    localparam logic [PW-1:0] POS_LAST = PW'(FRAME - 1);

    typedef enum logic [1:0] {
        FMT_I2S = 2'd0,
        FMT_LJ  = 2'd1,
        FMT_RJ  = 2'd2,
        FMT_ALT = 2'd3
    } fmt_e;

    if (SAMPLE_W < 1 || SAMPLE_W >= SLOT_W) begin : g_bad_params
        $error("i2s_tx_gen: need 1 <= SAMPLE_W < SLOT_W");
    end

    logic [PW-1:0]       pos;
    logic [PW-1:0]       pos_nxt;
    logic                bit_upd;
    logic                frame_start;
    logic                hold_full;
    logic                take;
    logic [SAMPLE_W-1:0] hold_l, hold_r;
    logic [SAMPLE_W-1:0] buf_l, buf_r;
    logic [SAMPLE_W-1:0] bl_eff, br_eff;
    fmt_e                fmt_q, fmt_eff;
    logic                lr_nxt, sd_nxt;

    // A strobe while bclk is high is the falling toggle, i.e. a bit update.
    assign bit_upd     = strobe & bclk;
    assign pos_nxt     = (pos == POS_LAST) ? '0 : pos + 1'b1;
    assign frame_start = bit_upd & (pos == POS_LAST);

    assign smp.sample_ready = ~hold_full;
    assign take             = smp.sample_valid & ~hold_full;

    // At frame start the outgoing bit must already use the new frame's
    // format and sample, so bypass the registers on that clk.
    assign fmt_eff = frame_start ? fmt_e'(fmt) : fmt_q;
    assign bl_eff  = frame_start ? (hold_full ? hold_l : '0) : buf_l;
    assign br_eff  = frame_start ? (hold_full ? hold_r : '0) : buf_r;

    // Map the next position to word select and the serial data bit.
    always_comb begin
        int                  k;
        int                  idx;
        logic                right;
        logic [SAMPLE_W-1:0] s;
        k      = int'(pos_nxt);
        right  = 1'b0;
        if (k >= SLOT_W) begin
            k     = k - SLOT_W;
            right = 1'b1;
        end
        s      = right ? br_eff : bl_eff;
        idx    = -1;
        lr_nxt = right;
        case (fmt_eff)
            FMT_LJ: begin
                lr_nxt = ~right;
                if (k < SAMPLE_W) idx = SAMPLE_W - 1 - k;
            end
            FMT_RJ: begin
                lr_nxt = ~right;
                if (k >= SLOT_W - SAMPLE_W) idx = SLOT_W - 1 - k;
            end
            default: begin
                // I2S: one-bit delay after the word-select edge.
                if (k >= 1 && k <= SAMPLE_W) idx = SAMPLE_W - k;
            end
        endcase
        sd_nxt = 1'b0;
        for (int i = 0; i < SAMPLE_W; i++) begin
            if (i == idx) sd_nxt = s[i];
        end
    end

    // Bit clock, frame position and registered serial outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bclk     <= 1'b1;
            pos      <= POS_LAST;
            lrclk    <= 1'b0;
            sdata    <= 1'b0;
            underrun <= 1'b0;
            fmt_q    <= FMT_I2S;
            buf_l    <= '0;
            buf_r    <= '0;
        end else begin
            underrun <= 1'b0;
            if (strobe) bclk <= ~bclk;
            if (bit_upd) begin
                pos   <= pos_nxt;
                lrclk <= lr_nxt;
                sdata <= sd_nxt;
            end
            if (frame_start) begin
                fmt_q    <= fmt_eff;
                buf_l    <= bl_eff;
                buf_r    <= br_eff;
                underrun <= ~hold_full;
            end
        end
    end

    // Holding register: filled by handshake, drained only at frame start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_full <= 1'b0;
            hold_l    <= '0;
            hold_r    <= '0;
        end else begin
            if (frame_start && hold_full) begin
                hold_full <= 1'b0;
            end else if (take) begin
                hold_full <= 1'b1;
                hold_l    <= smp.sample_left;
                hold_r    <= smp.sample_right;
            end
        end
    end
endmodule

// File: tb/tb_i2s_tx_gen.sv
// Directed bench for i2s_tx_gen with default widths (16-bit samples,
// 32-bit slots). Frames are captured MSB-first: bit 63 holds pos 0.
module tb_i2s_tx_gen;
    localparam int SW = 16;
    localparam int SL = 32;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic       strobe  = 1'b0;
    logic [1:0] fmt     = 2'd0;
    logic       bclk, lrclk, sdata, underrun;

    int total  = 0;
    int bad    = 0;
    int ur_cnt = 0;

    logic [63:0] lr, sd;
    int          ur;
    logic        r0, r1;

    always #5 clk = ~clk;

    i2s_tx_gen_if #(.SAMPLE_W(SW)) smp ();

    i2s_tx_gen #(.SAMPLE_W(SW), .SLOT_W(SL)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .strobe   (strobe),
        .fmt      (fmt),
        .smp      (smp.slave),
        .bclk     (bclk),
        .lrclk    (lrclk),
        .sdata    (sdata),
        .underrun (underrun)
    );

    // Count every clk that underrun is high.
    always @(negedge clk) if (underrun === 1'b1) ur_cnt++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic offer(input logic [15:0] l, input logic [15:0] r);
        smp.sample_left  = l;
        smp.sample_right = r;
        smp.sample_valid = 1'b1;
        @(negedge clk);
        smp.sample_valid = 1'b0;
    endtask

    // Run n bit periods (falling + rising strobe each), capturing outputs
    // right after every bit update. Optionally change fmt at pos 32.
    task automatic run_bits(input int n, input logic chg, input logic [1:0] nf,
                            output logic [63:0] lr_o, output logic [63:0] sd_o,
                            output int ur_o, output logic rdy0, output logic rdy1);
        int u0;
        u0   = ur_cnt;
        lr_o = '0;
        sd_o = '0;
        rdy0 = 1'b0;
        rdy1 = 1'b0;
        for (int p = 0; p < n; p++) begin
            if (chg && p == 32) fmt = nf;
            strobe = 1'b1;
            @(negedge clk);
            strobe = 1'b0;
            lr_o = {lr_o[62:0], lrclk};
            sd_o = {sd_o[62:0], sdata};
            if (p == 0) rdy0 = smp.sample_ready;
            @(negedge clk);
            if (p == 0) rdy1 = smp.sample_ready;
            strobe = 1'b1;
            @(negedge clk);
            strobe = 1'b0;
            @(negedge clk);
        end
        ur_o = ur_cnt - u0;
    endtask

    initial begin
        smp.sample_left  = '0;
        smp.sample_right = '0;
        smp.sample_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_bclk",  64'(bclk), 64'd1);
        chk("rst_lrclk", 64'(lrclk), 64'd0);
        chk("rst_sdata", 64'(sdata), 64'd0);
        chk("rst_ur",    64'(underrun), 64'd0);
        chk("rst_ready", 64'(smp.sample_ready), 64'd1);
        reset_n = 1'b1;
        @(negedge clk);

        // I2S, sample accepted before the first strobe
        offer(16'hAAFF, 16'h0000);
        chk("acc_ready", 64'(smp.sample_ready), 64'd0);
        run_bits(64, 1'b0, 2'd0, lr, sd, ur, r0, r1);
        chk("i2s_sd", sd, 64'h557F_8000_0000_0000);
        chk("i2s_lr", lr, 64'h0000_0000_FFFF_FFFF);
        chk("i2s_ur", 64'(ur), 64'd0);

        // Left-justified
        fmt = 2'd1;
        offer(16'h8001, 16'h0000);
        run_bits(64, 1'b0, 2'd0, lr, sd, ur, r0, r1);
        chk("lj_sd", sd, 64'h8001_0000_0000_0000);
        chk("lj_lr", lr, 64'hFFFF_FFFF_0000_0000);
        chk("lj_ur", 64'(ur), 64'd0);

        // Right-justified
        fmt = 2'd2;
        offer(16'h0000, 16'h0001);
        run_bits(64, 1'b0, 2'd0, lr, sd, ur, r0, r1);
        chk("rj_sd", sd, 64'h0000_0000_0000_0001);
        chk("rj_lr", lr, 64'hFFFF_FFFF_0000_0000);

        // Underrun: no sample offered
        fmt = 2'd0;
        run_bits(64, 1'b0, 2'd0, lr, sd, ur, r0, r1);
        chk("ur_pulse", 64'(ur), 64'd1);
        chk("ur_sd", sd, 64'd0);

        // Backpressure: A then B with valid held high; fmt changed mid-frame
        smp.sample_left  = 16'hFFFF;
        smp.sample_right = 16'h0000;
        smp.sample_valid = 1'b1;
        @(negedge clk);
        chk("bp_full", 64'(smp.sample_ready), 64'd0);
        smp.sample_left  = 16'h0000;
        smp.sample_right = 16'hF00F;
        repeat (5) @(negedge clk);
        chk("bp_hold", 64'(smp.sample_ready), 64'd0);
        run_bits(64, 1'b1, 2'd1, lr, sd, ur, r0, r1);
        smp.sample_valid = 1'b0;
        chk("bp_rdy_fs", 64'(r0), 64'd1);
        chk("bp_b_take", 64'(r1), 64'd0);
        chk("bp_a_sd", sd, 64'h7FFF_8000_0000_0000);
        chk("bp_a_lr", lr, 64'h0000_0000_FFFF_FFFF);
        chk("bp_a_ur", 64'(ur), 64'd0);
        run_bits(64, 1'b0, 2'd0, lr, sd, ur, r0, r1);
        chk("bp_b_sd", sd, 64'h0000_0000_F00F_0000);
        chk("bp_b_lr", lr, 64'hFFFF_FFFF_0000_0000);
        chk("bp_b_ur", 64'(ur), 64'd0);

        // Reset mid-frame with a sample held
        offer(16'hFFFF, 16'hFFFF);
        run_bits(20, 1'b0, 2'd0, lr, sd, ur, r0, r1);
        offer(16'h1234, 16'h5678);
        chk("mid_held", 64'(smp.sample_ready), 64'd0);
        strobe = 1'b1;
        @(negedge clk);
        strobe = 1'b0;
        chk("mid_bclk", 64'(bclk), 64'd0);
        chk("mid_lrclk", 64'(lrclk), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_bclk",  64'(bclk), 64'd1);
        chk("arst_lrclk", 64'(lrclk), 64'd0);
        chk("arst_sdata", 64'(sdata), 64'd0);
        chk("arst_ready", 64'(smp.sample_ready), 64'd1);
        @(negedge clk);
        reset_n = 1'b1;
        fmt = 2'd0;
        @(negedge clk);
        run_bits(64, 1'b0, 2'd0, lr, sd, ur, r0, r1);
        chk("post_rst_ur", 64'(ur), 64'd1);
        chk("post_rst_sd", sd, 64'd0);
        chk("post_rst_lr", lr, 64'h0000_0000_FFFF_FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
